// File: rtl/core_mtimer_if.sv
// MMIO request/response bundle between a bus master and core_mtimer.
// Request is accepted when mmio_req && mmio_gnt; response one cycle later.
interface core_mtimer_if #(
  parameter int AW = 12
);
  logic          mmio_req;
  logic          mmio_gnt;
  logic          mmio_wen;
  logic [7:0]    mmio_strb;
  logic [AW-1:0] mmio_addr;
  logic [63:0]   mmio_wdata;
  logic          mmio_rvalid;
  logic [63:0]   mmio_rdata;
  logic          mmio_error;

  modport master (
    output mmio_req,
    output mmio_wen,
    output mmio_strb,
    output mmio_addr,
    output mmio_wdata,
    input  mmio_gnt,
    input  mmio_rvalid,
    input  mmio_rdata,
    input  mmio_error
  );

  modport slave (
    input  mmio_req,
    input  mmio_wen,
    input  mmio_strb,
    input  mmio_addr,
    input  mmio_wdata,
    output mmio_gnt,
    output mmio_rvalid,
    output mmio_rdata,
    output mmio_error
  );
endinterface

// File: rtl/core_mtimer.sv
// Machine timer + software interrupt source (mtime/mtimecmp/msip over MMIO).
// Optional CORE_MTIMER_PRESCALE_EN adds a 16-bit tick prescaler at 0x18.
module core_mtimer #(
  parameter int          AW        = 12,
  parameter logic [63:0] MTIME_RST = 64'd0
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  core_mtimer_if.slave  bus,
  output logic          int_ti,
  output logic          int_sw
);

  localparam logic [AW-1:0] A_TIME = AW'(0);
  localparam logic [AW-1:0] A_CMP  = AW'(8);
  localparam logic [AW-1:0] A_MSIP = AW'(16);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        msip_q, msip_d;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        ti_q, ti_d;
  logic        sw_q, sw_d;

  logic        acc;
  logic        wr;
  logic        sel_time;
  logic        sel_cmp;
  logic        sel_msip;
  logic        sel_presc;
  logic        hit;
  logic        tick;
  logic [63:0] bmask;
  logic [63:0] rd_val;

  assign bus.mmio_gnt = g_resetn;

  assign acc = bus.mmio_req & bus.mmio_gnt;
  assign wr  = acc & bus.mmio_wen;

  // Map entries are 8-aligned, so a misaligned address never selects one.
  assign sel_time = bus.mmio_addr == A_TIME;
  assign sel_cmp  = bus.mmio_addr == A_CMP;
  assign sel_msip = bus.mmio_addr == A_MSIP;
  assign hit = sel_time | sel_cmp | sel_msip | sel_presc;

`ifdef CORE_MTIMER_PRESCALE_EN
  localparam logic [AW-1:0] A_PRESC = AW'(24);

  logic [15:0] presc_q, presc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;

  assign sel_presc = bus.mmio_addr == A_PRESC;
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  // cnt_q counts elapsed cycles, so prescale P ticks every max(P,1) cycles.
  assign tick = cnt_inc >= {1'b0, presc_q};

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_inc[15:0];
    if (tick)
      cnt_d = 16'd0;
    if (wr & sel_presc) begin
      presc_d = (presc_q & ~bmask[15:0])
              | (bus.mmio_wdata[15:0] & bmask[15:0]);
      cnt_d   = 16'd0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      presc_q <= 16'd0;
      cnt_q   <= 16'd0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign sel_presc = 1'b0;
  assign tick      = 1'b1;
`endif

  always_comb begin
    bmask = '0;
    for (int i = 0; i < 8; i++)
      bmask[i*8 +: 8] = {8{bus.mmio_strb[i]}};
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_time: rd_val = mtime_q;
      sel_cmp:  rd_val = cmp_q;
      sel_msip: rd_val = {63'd0, msip_q};
`ifdef CORE_MTIMER_PRESCALE_EN
      sel_presc: rd_val = {48'd0, presc_q};
`endif
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    msip_d  = msip_q;
    // A write to mtime wins over the tick increment in the same cycle.
    if (wr & sel_time)
      mtime_d = (mtime_q & ~bmask)
              | (bus.mmio_wdata & bmask);
    else if (tick)
      mtime_d = mtime_q + 64'd1;
    if (wr & sel_cmp)
      cmp_d = (cmp_q & ~bmask)
            | (bus.mmio_wdata & bmask);
    if (wr & sel_msip & bus.mmio_strb[0])
      msip_d = bus.mmio_wdata[0];
  end

  always_comb begin
    rvalid_d = acc;
    error_d  = acc & ~hit;
    rdata_d  = '0;
    if (acc & ~bus.mmio_wen & hit)
      rdata_d = rd_val;
    ti_d = mtime_q >= cmp_q;
    sw_d = msip_d;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      mtime_q  <= MTIME_RST;
      cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 64'd0;
      error_q  <= 1'b0;
      ti_q     <= 1'b0;
      sw_q     <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      msip_q   <= msip_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
      ti_q     <= ti_d;
      sw_q     <= sw_d;
    end
  end

  assign bus.mmio_rvalid = rvalid_q;
  assign bus.mmio_rdata  = rdata_q;
  assign bus.mmio_error  = error_q;
  assign int_ti = ti_q;
  assign int_sw = sw_q;

endmodule

// File: tb/tb_core_mtimer.sv
// Directed + random bench for core_mtimer against a register-level model.
// Prescaler steps are built only when CORE_MTIMER_PRESCALE_EN is defined.
module tb_core_mtimer;

  logic g_clk    = 1'b0;
  logic g_resetn = 1'b0;
  logic int_ti;
  logic int_sw;

  core_mtimer_if #(.AW(12)) bus();

  core_mtimer #(
    .AW(12),
    .MTIME_RST(64'd0)
  ) dut (
    .g_clk(g_clk),
    .g_resetn(g_resetn),
    .bus(bus),
    .int_ti(int_ti),
    .int_sw(int_sw)
  );

  always #5 g_clk = ~g_clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic        m_msip;
  int          m_presc;
  int          m_cnt;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old,
                                        input logic [63:0] wd,
                                        input logic [7:0]  strb);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 8; i++)
      if (strb[i]) m = m | (64'hFF << (8 * i));
    return (old & ~m) | (wd & m);
  endfunction

  function automatic bit mapped(input logic [11:0] a);
    bit r;
    r = (a == 12'h000) || (a == 12'h008) || (a == 12'h010);
`ifdef CORE_MTIMER_PRESCALE_EN
    r = r || (a == 12'h018);
`endif
    return r;
  endfunction

  function automatic logic [63:0] mreg(input logic [11:0] a);
    logic [63:0] v;
    v = 64'd0;
    if (a == 12'h000) v = m_time;
    if (a == 12'h008) v = m_cmp;
    if (a == 12'h010) v = {63'd0, m_msip};
    if (a == 12'h018) v = 64'(m_presc);
    return v;
  endfunction

  task automatic model_reset();
    m_time  = 64'd0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip  = 1'b0;
    m_presc = 0;
    m_cnt   = 0;
  endtask

  // One clock with an optional request; model advanced by the spec rules.
  task automatic step(input bit          req,
                      input bit          wen,
                      input logic [7:0]  strb,
                      input logic [11:0] addr,
                      input logic [63:0] wdata);
    bit          ex_rv, ex_err, ex_ti, tk, ok;
    logic [63:0] ex_rd;
    int          per;
    bus.mmio_req   = req;
    bus.mmio_wen   = wen;
    bus.mmio_strb  = strb;
    bus.mmio_addr  = addr;
    bus.mmio_wdata = wdata;
    ok     = mapped(addr);
    ex_rv  = req;
    ex_err = req && !ok;
    ex_rd  = (req && !wen && ok) ? mreg(addr) : 64'd0;
    ex_ti  = m_time >= m_cmp;
    tk     = 1'b1;
`ifdef CORE_MTIMER_PRESCALE_EN
    per = (m_presc < 2) ? 1 : m_presc;
    tk  = (m_cnt + 1) >= per;
    m_cnt = tk ? 0 : m_cnt + 1;
`else
    per = 1;
`endif
    if (req && wen && addr == 12'h000)
      m_time = merge(m_time, wdata, strb);
    else if (tk)
      m_time = m_time + 64'd1;
    if (req && wen && addr == 12'h008)
      m_cmp = merge(m_cmp, wdata, strb);
    if (req && wen && addr == 12'h010 && strb[0])
      m_msip = wdata[0];
`ifdef CORE_MTIMER_PRESCALE_EN
    if (req && wen && addr == 12'h018) begin
      m_presc = int'(merge(64'(m_presc), wdata, strb) & 64'hFFFF);
      m_cnt   = 0;
    end
`endif
    chk("gnt", 64'(bus.mmio_gnt), 64'd1);
    @(posedge g_clk);
    #1;
    chk("rvalid", 64'(bus.mmio_rvalid), 64'(ex_rv));
    chk("int_ti", 64'(int_ti), 64'(ex_ti));
    chk("int_sw", 64'(int_sw), 64'(m_msip));
    if (ex_rv) begin
      chk("error", 64'(bus.mmio_error), 64'(ex_err));
      chk("rdata", bus.mmio_rdata, ex_rd);
    end
    if (per < 0) $display("unreachable");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 8'h00, 12'h000, 64'd0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    step(1'b1, 1'b1, 8'hFF, a, d);
  endtask

  task automatic rd(input logic [11:0] a);
    step(1'b1, 1'b0, 8'h00, a, 64'd0);
  endtask

  // Reset is held over a pending read request: no response may appear.
  task automatic do_reset();
    g_resetn       = 1'b0;
    bus.mmio_req   = 1'b1;
    bus.mmio_wen   = 1'b0;
    bus.mmio_strb  = 8'h00;
    bus.mmio_addr  = 12'h000;
    bus.mmio_wdata = 64'd0;
    @(posedge g_clk);
    #1;
    chk("rst_gnt", 64'(bus.mmio_gnt), 64'd0);
    @(posedge g_clk);
    #1;
    chk("rst_rvalid", 64'(bus.mmio_rvalid), 64'd0);
    chk("rst_rdata", bus.mmio_rdata, 64'd0);
    chk("rst_error", 64'(bus.mmio_error), 64'd0);
    chk("rst_int_ti", 64'(int_ti), 64'd0);
    chk("rst_int_sw", 64'(int_sw), 64'd0);
    model_reset();
    bus.mmio_req = 1'b0;
    g_resetn     = 1'b1;
  endtask

  logic [11:0] addr_tab [6];

  initial begin
    addr_tab[0] = 12'h000;
    addr_tab[1] = 12'h008;
    addr_tab[2] = 12'h010;
    addr_tab[3] = 12'h018;
    addr_tab[4] = 12'h004;
    addr_tab[5] = 12'h020;
    model_reset();

    // 1: reset value, then free-run 10 cycles
    do_reset();
    rd(12'h000);
    idle(10);
    rd(12'h000);
    rd(12'h010);

    // 2: compare against a small mtimecmp, then push it away
    do_reset();
    wr(12'h008, 64'd20);
    idle(24);
    wr(12'h008, 64'd1000);
    idle(3);

    // 3: wrap of mtime around 2^64
    wr(12'h000, 64'hFFFF_FFFF_FFFF_FFFE);
    wr(12'h008, 64'd2);
    idle(8);
    rd(12'h000);

    // 4: software interrupt, including a strb=0 no-op
    wr(12'h010, 64'd1);
    rd(12'h010);
    step(1'b1, 1'b1, 8'h00, 12'h010, 64'd0);
    wr(12'h010, 64'd0);
    rd(12'h010);
    step(1'b1, 1'b1, 8'hFE, 12'h010, 64'd1);
    rd(12'h010);

    // 5: address errors back-to-back, registers must be untouched
    rd(12'h004);
    rd(12'h020);
    wr(12'h00C, 64'h1234);
    wr(12'h018, 64'd7);
    rd(12'h008);
    rd(12'h018);

    // partial-byte write to mtime
    step(1'b1, 1'b1, 8'h0F, 12'h000, 64'hAAAA_BBBB_0000_0100);
    rd(12'h000);

`ifdef CORE_MTIMER_PRESCALE_EN
    // 6: prescaled tick
    do_reset();
    wr(12'h018, 64'd4);
    idle(13);
    rd(12'h000);
    rd(12'h018);
    wr(12'h018, 64'd1);
    idle(3);
    rd(12'h000);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bit          rq, we;
      logic [7:0]  sb;
      logic [11:0] ad;
      logic [63:0] wd;
      rq = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) == 1;
      sb = 8'($urandom);
      ad = addr_tab[$urandom_range(0, 5)];
      wd = {$urandom, $urandom};
      if (ad == 12'h008 && $urandom_range(0, 1) == 1)
        wd = m_time + 64'($urandom_range(0, 6));
      if (ad == 12'h018)
        wd = 64'($urandom_range(0, 5));
      step(rq, we, sb, ad, wd);
    end

    // reset while a read is presented, then recover
    do_reset();
    rd(12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
